// File: rtl/fft_pkg.sv
// Constants, complex sample type and index helper shared by the 16-point FFT pipeline and its reorder buffer.
package fft_pkg;

  localparam int FFT_N          = 16;
  localparam int FFT_LOG2_N     = 4;
  localparam int FFT_DATA_WIDTH = 12;

  typedef struct packed {
    logic [FFT_DATA_WIDTH-1:0] re;
    logic [FFT_DATA_WIDTH-1:0] im;
  } cplx_t;

  function automatic logic [FFT_LOG2_N-1:0] bitrev4(input logic [FFT_LOG2_N-1:0] x);
    return {x[0], x[1], x[2], x[3]};
  endfunction

endpackage

// File: rtl/reorder_bank.sv
// One frame of sample storage: synchronous write port, asynchronous read port.
// No reset; contents are only meaningful once the owning bank has been marked full.
module reorder_bank #(
  parameter int WIDTH  = 24,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_reorder.sv
// Ping-pong bit-reversal buffer: bin 0 of a frame leaves 2 cycles after its last input; stall_up is registered-only.
// Optional out_last marker is built when FFT_REORDER_LAST_EN is defined.
module fft_reorder
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int LOG2_N     = FFT_LOG2_N
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_r,
  input  logic [DATA_WIDTH-1:0] in_i,
  output logic                  stall_up,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_r,
  output logic [DATA_WIDTH-1:0] out_i,
`ifdef FFT_REORDER_LAST_EN
  output logic                  out_last,
`endif
  output logic                  overflow
);

  localparam int SW = 2 * DATA_WIDTH;
  localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(FFT_N - 1);
  localparam logic [LOG2_N-1:0] IDX_ONE  = LOG2_N'(1);

  logic              wr_bank;
  logic              rd_bank;
  logic [LOG2_N-1:0] wr_idx;
  logic [LOG2_N-1:0] rd_idx;
  logic [1:0]        full;
  logic [1:0]        full_nxt;
  logic [SW-1:0]     bank_word [2];
  logic [SW-1:0]     rd_word;

  logic accept;
  logic load;
  logic wr_last;
  logic rd_last;

  assign stall_up = full[wr_bank];
  assign accept   = in_valid && !stall_up;
  assign load     = full[rd_bank] && (!out_valid || out_ready);
  assign wr_last  = accept && (wr_idx == LAST_IDX);
  assign rd_last  = load && (rd_idx == LAST_IDX);
  assign rd_word  = bank_word[rd_bank];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    reorder_bank #(
      .WIDTH  (SW),
      .ADDR_W (LOG2_N)
    ) u_bank (
      .clk   (clk),
      .we    (accept && (wr_bank == 1'(b))),
      .waddr (bitrev4(wr_idx)),
      .wdata ({in_r, in_i}),
      .raddr (rd_idx),
      .rdata (bank_word[b])
    );
  end

  // A set and a clear never target the same bank: writing needs it empty, clearing needs it full.
  always_comb begin
    full_nxt = full;
    if (wr_last) full_nxt[wr_bank] = 1'b1;
    if (rd_last) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      full      <= '0;
      out_valid <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
      overflow  <= 1'b0;
    end else begin
      full <= full_nxt;
      if (accept) begin
        wr_idx <= wr_idx + IDX_ONE;
        if (wr_last) wr_bank <= ~wr_bank;
      end
      if (load) begin
        out_valid <= 1'b1;
        out_r     <= rd_word[SW-1:DATA_WIDTH];
        out_i     <= rd_word[DATA_WIDTH-1:0];
        rd_idx    <= rd_idx + IDX_ONE;
        if (rd_last) rd_bank <= ~rd_bank;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (in_valid && stall_up) overflow <= 1'b1;
    end
  end

`ifdef FFT_REORDER_LAST_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_last <= 1'b0;
    end else if (load) begin
      out_last <= (rd_idx == LAST_IDX);
    end
  end
`endif

endmodule

// File: tb/tb_fft_reorder.sv
// Randomized bench for fft_reorder against a frame-level reference model.
module tb_fft_reorder;

  localparam int DW = 12;
`ifdef FFT_REORDER_LAST_EN
  localparam bit HAS_LAST = 1'b1;
`else
  localparam bit HAS_LAST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_r = '0;
  logic [DW-1:0] in_i = '0;
  logic          stall_up;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_r;
  logic [DW-1:0] out_i;
  logic          overflow;
  logic          dut_last;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fft_reorder #(.DATA_WIDTH(DW), .LOG2_N(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_r      (in_r),
    .in_i      (in_i),
    .stall_up  (stall_up),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_i     (out_i),
`ifdef FFT_REORDER_LAST_EN
    .out_last  (dut_last),
`endif
    .overflow  (overflow)
  );
`ifndef FFT_REORDER_LAST_EN
  assign dut_last = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] r;
    logic [DW-1:0] i;
    logic          l;
  } smp_t;
  typedef logic [2*DW-1:0] frame_t [16];

  smp_t   exp_q[$];
  smp_t   got_q[$];
  frame_t m_frames[$];
  logic [2*DW-1:0] part [16];
  int     pcnt = 0;
  int     rdp = 0;
  logic   m_valid = 1'b0;
  logic [DW-1:0] m_r = '0;
  logic [DW-1:0] m_i = '0;
  logic   m_last = 1'b0;
  logic   m_ovf = 1'b0;
  int     ramp_exp [16];

  function automatic int brev(input int x);
    int y = 0;
    for (int k = 0; k < 4; k++) begin
      y = y * 2 + (x % 2);
      x = x / 2;
    end
    return y;
  endfunction

  // Reference: complete frames queue up in natural order; at most two may be held.
  always @(posedge clk) begin : model
    bit stl, ld;
    frame_t f;
    if (rst) begin
      m_frames.delete();
      exp_q.delete();
      pcnt = 0; rdp = 0;
      m_valid = 0; m_r = '0; m_i = '0; m_last = 0; m_ovf = 0;
    end else begin
      stl = (m_frames.size() == 2);
      ld  = (m_frames.size() > 0) && (!m_valid || out_ready);
      if (ld) begin
        m_valid = 1'b1;
        {m_r, m_i} = m_frames[0][rdp];
        m_last = (rdp == 15);
        rdp++;
        if (rdp == 16) begin
          void'(m_frames.pop_front());
          rdp = 0;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      if (in_valid && stl) m_ovf = 1'b1;
      if (in_valid && !stl) begin
        part[pcnt] = {in_r, in_i};
        pcnt++;
        if (pcnt == 16) begin
          for (int k = 0; k < 16; k++) f[k] = part[brev(k)];
          m_frames.push_back(f);
          for (int k = 0; k < 16; k++)
            exp_q.push_back('{r: f[k][2*DW-1:DW], i: f[k][DW-1:0], l: (k == 15)});
          pcnt = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) got_q.push_back('{r: out_r, i: out_i, l: dut_last});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sample(input logic [DW-1:0] r, input logic [DW-1:0] i);
    in_valid = 1'b1; in_r = r; in_i = i;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    got_q.delete();
  endtask

  task automatic drain(input int budget);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < budget && got_q.size() < exp_q.size(); k++) tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_r = 12'h5a5; in_i = 12'h3c3;
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if ({out_valid, out_r, out_i, stall_up, overflow, dut_last} !== '0) begin
        miscompares++;
        $display("FAIL reset_state: got v=%b r=%h i=%h stall=%b ovf=%b last=%b want all 0",
                 out_valid, out_r, out_i, stall_up, overflow, dut_last);
      end
      tick();
    end
    in_valid = 1'b0;
    do_reset();
  endtask

  // Expects a freshly reset DUT.
  task automatic test_ramp(input string nm);
    out_ready = 1'b1;
    for (int j = 0; j < 16; j++) send_sample(DW'(j), '0);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_latency_early: out_valid=%b want 0", nm, out_valid);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_r !== '0) begin
      miscompares++;
      $display("FAIL %s_latency: out_valid=%b out_r=%0d want 1 and 0", nm, out_valid, out_r);
    end
    drain(40);
    vectors++;
    if (got_q.size() != 16) begin
      miscompares++;
      $display("FAIL %s_count: got %0d outputs want 16", nm, got_q.size());
    end
    for (int k = 0; k < 16 && k < got_q.size(); k++) begin
      vectors++;
      if (got_q[k].r !== DW'(ramp_exp[k]) || got_q[k].i !== '0 || (HAS_LAST && got_q[k].l !== (k == 15))) begin
        miscompares++;
        $display("FAIL %s_seq[%0d]: got r=%0d i=%0d last=%b want r=%0d i=0 last=%b",
                 nm, k, got_q[k].r, got_q[k].i, got_q[k].l, ramp_exp[k], k == 15);
      end
    end
  endtask

  task automatic test_stream();
    int cyc = 0, first = -1, last = -1, nval = 0;
    bit stall_seen = 0;
    do_reset();
    out_ready = 1'b1;
    for (int j = 0; j < 64 + 40; j++) begin
      if (out_valid) begin
        nval++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (stall_up) stall_seen = 1'b1;
      if (j < 64) send_sample(DW'($urandom), DW'($urandom));
      else tick();
      cyc++;
    end
    vectors++;
    if (nval != 64 || last - first + 1 != 64) begin
      miscompares++;
      $display("FAIL stream_contiguous: got %0d valid over %0d cycles want 64 over 64", nval, last - first + 1);
    end
    vectors++;
    if (stall_seen || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_flags: stall_seen=%b overflow=%b want 0 0", stall_seen, overflow);
    end
    vectors++;
    if (got_q.size() != 64 || exp_q.size() != 64) begin
      miscompares++;
      $display("FAIL stream_count: got %0d model %0d want 64", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      vectors++;
      if (got_q[k].r !== exp_q[k].r || got_q[k].i !== exp_q[k].i || (HAS_LAST && got_q[k].l !== exp_q[k].l)) begin
        miscompares++;
        $display("FAIL stream_data[%0d]: got %h/%h want %h/%h", k, got_q[k].r, got_q[k].i, exp_q[k].r, exp_q[k].i);
      end
    end
  endtask

  task automatic test_hold_overflow();
    logic [2*DW:0] snap;
    do_reset();
    out_ready = 1'b0;
    for (int j = 0; j < 32; j++) begin
      if (j == 31) begin
        vectors++;
        if (stall_up !== 1'b0) begin
          miscompares++;
          $display("FAIL hold_stall_early: stall_up=%b want 0", stall_up);
        end
      end
      send_sample(DW'($urandom), DW'($urandom));
    end
    vectors++;
    if (stall_up !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_stall: stall_up=%b want 1", stall_up);
    end
    snap = {out_valid, out_r, out_i};
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_valid: out_valid=%b want 1", out_valid);
    end
    for (int j = 0; j < 8; j++) begin
      send_sample(DW'($urandom), DW'($urandom));
      vectors++;
      if ({out_valid, out_r, out_i} !== snap || stall_up !== 1'b1) begin
        miscompares++;
        $display("FAIL hold_stable[%0d]: got %h stall=%b want %h stall=1", j, {out_valid, out_r, out_i}, stall_up, snap);
      end
    end
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_set: overflow=%b want 1", overflow);
    end
    drain(80);
    vectors++;
    if (got_q.size() != 32 || exp_q.size() != 32) begin
      miscompares++;
      $display("FAIL hold_count: got %0d model %0d want 32", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      vectors++;
      if (got_q[k].r !== exp_q[k].r || got_q[k].i !== exp_q[k].i || (HAS_LAST && got_q[k].l !== exp_q[k].l)) begin
        miscompares++;
        $display("FAIL hold_data[%0d]: got %h/%h want %h/%h", k, got_q[k].r, got_q[k].i, exp_q[k].r, exp_q[k].i);
      end
    end
    vectors++;
    if (overflow !== 1'b1 || stall_up !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_sticky: overflow=%b stall=%b want 1 0", overflow, stall_up);
    end
  endtask

  task automatic test_bubble();
    int cyc = 0, first = -1, last = -1, nhs = 0;
    do_reset();
    out_ready = 1'b1;
    for (int j = 0; j < 80; j++) begin
      out_ready = (j != 20);
      if (out_valid && out_ready) begin
        nhs++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (j < 32) send_sample(DW'($urandom), DW'($urandom));
      else tick();
      cyc++;
    end
    vectors++;
    if (nhs != 32 || last - first + 1 != 33) begin
      miscompares++;
      $display("FAIL bubble_cost: got %0d handshakes over %0d cycles want 32 over 33", nhs, last - first + 1);
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      vectors++;
      if (got_q[k].r !== exp_q[k].r || got_q[k].i !== exp_q[k].i) begin
        miscompares++;
        $display("FAIL bubble_data[%0d]: got %h/%h want %h/%h", k, got_q[k].r, got_q[k].i, exp_q[k].r, exp_q[k].i);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_r      = DW'($urandom);
      in_i      = DW'($urandom);
      out_ready = ($urandom_range(0, 9) < 5);
      tick();
      vectors++;
      if (stall_up !== (m_frames.size() == 2) || out_valid !== m_valid || out_r !== m_r ||
          out_i !== m_i || overflow !== m_ovf || (HAS_LAST && dut_last !== m_last)) begin
        miscompares++;
        $display("FAIL random_cycle[%0d]: got s=%b v=%b r=%h i=%h o=%b l=%b want s=%b v=%b r=%h i=%h o=%b l=%b",
                 c, stall_up, out_valid, out_r, out_i, overflow, dut_last,
                 m_frames.size() == 2, m_valid, m_r, m_i, m_ovf, m_last);
      end
    end
    drain(80);
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL random_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      vectors++;
      if (got_q[k].r !== exp_q[k].r || got_q[k].i !== exp_q[k].i || (HAS_LAST && got_q[k].l !== exp_q[k].l)) begin
        miscompares++;
        $display("FAIL random_data[%0d]: got %h/%h want %h/%h", k, got_q[k].r, got_q[k].i, exp_q[k].r, exp_q[k].i);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    for (int j = 0; j < 23; j++) send_sample(DW'($urandom_range(1, 4095)), DW'($urandom_range(1, 4095)));
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++;
      if ({out_valid, out_r, out_i, stall_up, overflow, dut_last} !== '0) begin
        miscompares++;
        $display("FAIL midreset_zero[%0d]: got v=%b r=%h i=%h stall=%b ovf=%b want all 0",
                 k, out_valid, out_r, out_i, stall_up, overflow);
      end
    end
    rst = 1'b0;
    got_q.delete();
    test_ramp("midreset_ramp");
  endtask

  task automatic test_last();
    bit seen = 0;
    do_reset();
    out_ready = 1'b0;
    for (int j = 0; j < 16; j++) send_sample(DW'(j), '0);
    out_ready = 1'b1;
    for (int k = 0; k < 30 && !seen; k++) begin
      tick();
      if (out_valid && out_r == 15) seen = 1'b1;
    end
    out_ready = 1'b0;
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL last_reach: bin 15 not presented within budget");
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (dut_last !== 1'b1 || out_valid !== 1'b1 || out_r !== DW'(15)) begin
        miscompares++;
        $display("FAIL last_hold[%0d]: got last=%b v=%b r=%0d want 1 1 15", k, dut_last, out_valid, out_r);
      end
    end
    drain(20);
  endtask

  initial begin
    ramp_exp = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    test_reset();
    test_ramp("ramp");
    test_stream();
    test_hold_overflow();
    test_bubble();
    test_random();
    test_reset_mid();
    if (HAS_LAST) test_last();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

endmodule
